load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  START  0            lowest valid byte address of the target memory
  TOP    (1<<16)-1    highest valid byte address of the target memory
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock; all state changes on its rising edge
  rst_b  in  1  reset, asynchronous, active-low
  req_valid  in  1  pipeline access request present
  req_ready  out  1  unit accepts a request this cycle
  req_we  in  1  1 = store, 0 = load
  req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
  req_addr  in  32  byte address
  req_wdata  in  32  store data, right-justified
  resp_valid  out  1  response present
  resp_ready  in  1  pipeline consumes the response
  resp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
  resp_err  out  1  misaligned, illegal funct3 or out-of-range access
  mem_addr  out  32  word-aligned byte address to memory
  mem_wdata  out  8x4 array [0:3]  bytes to memory; lane i = byte at mem_addr+i
  mem_we  out  1  memory write enable
  mem_rdata  in  8x4 array [0:3]  combinational read bytes from memory

Function
REQ-003 The unit SHALL drive mem_addr = {req_addr[31:2],2'b00}, latched at acceptance; lane = addr[1:0].
REQ-004 The FSM SHALL have states IDLE, LOAD, RMW_RD, STORE and RESP.
REQ-005 req_ready SHALL be 1 exactly when the state is IDLE; acceptance = req_valid & req_ready.
REQ-006 On acceptance, req_we, funct3, addr and wdata SHALL be latched; later req_* changes are ignored.
REQ-007 The error check SHALL flag: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 outside {000,001,010,100,101} for loads or {000,001,010} for stores; mem_addr < START or mem_addr+3 > TOP.
REQ-008 An erroring request SHALL go IDLE->RESP with resp_err=1, resp_rdata=0 and no mem_we pulse.
REQ-009 A load SHALL go IDLE->LOAD->RESP; LOAD captures mem_rdata at its end.
REQ-010 Load formatting: B/BU select lane addr[1:0]; H/HU select lanes {addr[1]*2+1, addr[1]*2}; W = {lane3,lane2,lane1,lane0}; B/H sign-extend; BU/HU zero-extend.
REQ-011 A store word SHALL go IDLE->STORE->RESP, with mem_we=1 for the single STORE cycle and mem_wdata lane i = wdata[8i+7:8i].
REQ-012 A store byte or halfword SHALL go IDLE->RMW_RD->STORE->RESP.
REQ-013 RMW_RD SHALL capture mem_rdata; STORE then writes the captured word with only the addressed lanes replaced by wdata[7:0] or wdata[15:0].
REQ-014 mem_we SHALL be 1 only in STORE.
REQ-015 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_ready=1; the state then returns to IDLE.
REQ-016 Latency from acceptance to the first resp_valid cycle SHALL be: error 1, load 2, store word 2, sub-word store 3.
REQ-017 A request is not accepted in the RESP cycle even when resp_ready=1; the next acceptance is earliest in the following IDLE cycle.
REQ-018 mem_wdata SHALL be 0 outside STORE.

Reset
REQ-019 rst_b=0 SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, and clear all latched request fields.
REQ-020 Reset asserted mid-operation, including during STORE, SHALL deassert mem_we asynchronously; the aborted access produces no response.

Verification
REQ-021 Memory word @0x10 = 0x8899AABB; LB addr 0x12 -> resp_rdata 0xFFFFFF99 two cycles after acceptance; LBU -> 0x00000099.
REQ-022 Memory word @0x20 = 0x11223344; SH addr 0x22 wdata 0x0000BEEF -> exactly one mem_we cycle, 3-cycle latency, word becomes 0xBEEF3344.
REQ-023 SW addr 0x04 wdata 0xDEADBEEF -> mem_wdata {EF,BE,AD,DE}, one mem_we cycle, then LW addr 0x04 returns 0xDEADBEEF.
REQ-024 LW addr 0x06 and LH addr 0x01 -> resp_err=1 after 1 cycle, no mem_we pulse; LW addr 0x10000 with default TOP -> resp_err=1.
REQ-025 Hold resp_ready=0 for 5 cycles during a response -> resp_valid and resp_rdata remain stable, req_ready=0; on release, req_ready=1 the next cycle.
REQ-026 Pulse rst_b low during the STORE cycle of an SB -> mem_we drops immediately, state is IDLE, and no resp_valid is produced.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store unit that splits pipeline requests into
// word-aligned memory accesses.
// Ports:
//   clk, rst_b                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_funct3          store/load and RISC-V width code
//   req_addr, req_wdata         byte address, right-justified store data
//   resp_valid/resp_ready       response handshake
//   resp_rdata, resp_err        extended load data, error flag
//   mem_addr, mem_we            word-aligned address, write enable
//   mem_wdata[0:3]              bytes to memory, lane i = mem_addr+i
//   mem_rdata[0:3]              combinational read bytes from memory
module load_store_unit #(
  parameter logic [31:0] START = 32'h0000_0000,
  parameter logic [31:0] TOP   = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata [0:3],
  output logic        mem_we,
  input  logic [7:0]  mem_rdata [0:3]
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        acc;
  logic        f3_ok;
  logic        mis;
  logic        oor;
  logic        req_bad;
  logic [33:0] wa;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;
  logic [31:0] ld_fmt;
  logic [7:0]  st_lane [0:3];

  assign acc = req_valid & req_ready;

  // Error check on the live request; the result is latched at acceptance.
  assign wa = {2'b00, req_addr[31:2], 2'b00};

  always_comb begin
    if (req_we)
      f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010,
                                 3'b100, 3'b101};
    mis = ((req_funct3[1:0] == 2'b01) & req_addr[0])
        | ((req_funct3 == 3'b010) & (|req_addr[1:0]));
    // Below START shows up as a borrow out of the subtraction.
    oor = 1'((wa - {2'b00, START}) >> 33)
        | ((wa + 34'd3) > {2'b00, TOP});
    req_bad = ~f3_ok | mis | oor;
  end

  // Load extraction from the current memory word.
  always_comb begin
    ld_b = mem_rdata[addr_q[1:0]];
    ld_h = {mem_rdata[{addr_q[1], 1'b1}],
            mem_rdata[{addr_q[1], 1'b0}]};
    ld_w = {mem_rdata[3], mem_rdata[2],
            mem_rdata[1], mem_rdata[0]};
    unique case (f3_q)
      3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_fmt = {24'h0, ld_b};
      3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_fmt = {16'h0, ld_h};
      default: ld_fmt = ld_w;
    endcase
  end

  // Store merge: word stores replace every lane, sub-word stores only the
  // addressed lanes of the word captured in RMW_RD.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_lane[i] = word_q[8*i +: 8];
      unique case (f3_q[1:0])
        2'b00: begin
          if (2'(i) == addr_q[1:0])
            st_lane[i] = wdata_q[7:0];
        end
        2'b01: begin
          if (1'(i >> 1) == addr_q[1])
            st_lane[i] = (i % 2 == 1) ? wdata_q[15:8]
                                      : wdata_q[7:0];
        end
        default: st_lane[i] = wdata_q[8*i +: 8];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_bad;
        rdata_q <= 32'h0;
      end
      if (state_q == LOAD)
        rdata_q <= ld_fmt;
      if (state_q == RMW_RD)
        word_q <= ld_w;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (req_bad)
            state_d = RESP;
          else if (!req_we)
            state_d = LOAD;
          else if (req_funct3 == 3'b010)
            state_d = STORE;
          else
            state_d = RMW_RD;
        end
      end
      LOAD:   state_d = RESP;
      RMW_RD: state_d = STORE;
      STORE:  state_d = RESP;
      RESP: begin
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign mem_we     = (state_q == STORE);
  assign mem_addr   = {addr_q[31:2], 2'b00};

  always_comb begin
    for (int i = 0; i < 4; i++)
      mem_wdata[i] = mem_we ? st_lane[i] : 8'h00;
  end

  // we_q is kept as part of the latched request for observability.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus random checks of load_store_unit
// against a byte-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata [0:3];
  logic        mem_we;
  logic [7:0]  mem_rdata [0:3];

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  int          we_cnt = 0;
  logic [31:0] wd_last = 32'h0;
  int          errors = 0;
  int          checks = 0;

  load_store_unit dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++)
      mem_rdata[i] = mem[{mem_addr[15:2], 2'(i)}];
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        mem[{mem_addr[15:2], 2'(i)}] <= mem_wdata[i];
      we_cnt  <= we_cnt + 1;
      wd_last <= {mem_wdata[3], mem_wdata[2],
                  mem_wdata[1], mem_wdata[0]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic set_word(input int a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) begin
      mem[a+k]     = v[8*k +: 8];
      ref_mem[a+k] = v[8*k +: 8];
    end
  endtask

  // Reference model: works on byte addresses and access sizes only.
  task automatic model(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd,
                       output int lat, output int nwe);
    int     size;
    logic   legal;
    longint v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we)
      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else
      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
           || (f3 == 3'd4) || (f3 == 3'd5);
    err = !legal || (longint'(a) % size != 0)
       || ((longint'(a) / 4) * 4 + 3 > 65535);
    rd  = 32'h0;
    nwe = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      v = 0;
      for (int k = 0; k < size; k++)
        v += longint'(ref_mem[int'(a) + k]) << (8 * k);
      if (f3[2] == 1'b0 && size < 4 && v >= (64'd1 << (8*size - 1)))
        v -= (64'd1 << (8 * size));
      rd = v[31:0];
    end else begin
      lat = (size == 4) ? 2 : 3;
      nwe = 1;
      for (int k = 0; k < size; k++)
        ref_mem[int'(a) + k] = 8'((wd >> (8 * k)) & 32'hFF);
    end
  endtask

  task automatic access(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int hold);
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat, e_we, lat, w0;
    logic [31:0] rd0;
    logic        er0;
    model(we, f3, a, wd, e_err, e_rd, e_lat, e_we);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    w0 = we_cnt;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("resp_err", 32'(resp_err), 32'(e_err));
    check("resp_rdata", resp_rdata, e_rd);
    rd0 = resp_rdata;
    er0 = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, rd0);
      check("hold_err", 32'(resp_err), 32'(er0));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("we_pulses", 32'(we_cnt - w0), 32'(e_we));
    check("ready_after", 32'(req_ready), 32'd1);
    check("valid_after", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int          w0;
    rst_b      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", {mem_wdata[3], mem_wdata[2],
                            mem_wdata[1], mem_wdata[0]}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    set_word(32'h10, 32'h8899AABB);
    access(1'b0, 3'b000, 32'h12, 32'h0, 0);
    access(1'b0, 3'b100, 32'h12, 32'h0, 0);

    set_word(32'h20, 32'h11223344);
    access(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 0);
    check("sh_word", mem_word(32'h20), 32'hBEEF3344);
    access(1'b0, 3'b010, 32'h20, 32'h0, 0);

    access(1'b1, 3'b010, 32'h04, 32'hDEADBEEF, 0);
    check("sw_lanes", wd_last, 32'hDEADBEEF);
    access(1'b0, 3'b010, 32'h04, 32'h0, 0);

    access(1'b0, 3'b010, 32'h06, 32'h0, 0);
    access(1'b0, 3'b001, 32'h01, 32'h0, 0);
    access(1'b0, 3'b010, 32'h10000, 32'h0, 0);
    access(1'b1, 3'b100, 32'h08, 32'h0, 0);
    access(1'b0, 3'b010, 32'hFFFC, 32'h0, 0);

    access(1'b0, 3'b010, 32'h10, 32'h0, 5);

    // Reset pulse during the STORE cycle of a byte store.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h31;
    req_wdata  = 32'h5A;
    w0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("sb_store_we", 32'(mem_we), 32'd1);
    rst_b = 1'b0;
    #1;
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_valid", 32'(resp_valid), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("arst_no_resp", 32'(resp_valid), 32'd0);
    end
    resp_ready = 1'b0;
    check("arst_no_write", 32'(we_cnt - w0), 32'd0);
    access(1'b0, 3'b010, 32'h30, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0)
        ra = $urandom_range(0, 255);
      else
        ra = $urandom_range(32'hFFF0, 32'h10008);
      access(1'($urandom), 3'($urandom_range(0, 7)), ra,
             $urandom, $urandom_range(0, 2));
    end
    for (int n = 0; n < 16; n++)
      access(1'b0, 3'b010, 32'(4 * n), 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
